// File: rtl/vga_spi_pkg.sv
// rtl/vga_spi_pkg.sv - shared command codes, decode states and pixel width helper for the SPI framebuffer writer
package vga_spi_pkg;

    localparam logic [7:0] CMD_ALIGN    = 8'h80;
    localparam logic [7:0] CMD_SWAP     = 8'h81;
    localparam logic [7:0] CMD_SET_ADDR = 8'h82;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PIX_LO = 2'd1,
        ADDR   = 2'd2
    } fsm_state_t;

    // One byte per pixel carries RGB222, two bytes carry RGB444.
    function automatic int pix_width(input int bpp);
        return (bpp == 1) ? 6 : 12;
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// rtl/spi_byte_rx.sv - SPI mode-0 slave byte receiver with status byte shifted out on miso
module spi_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    input  logic [7:0] status,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       miso
);

    // [0] and [1] are the synchroniser stages, [2] holds the previous synchronised value
    logic [2:0] sclk_q, sclk_d;
    logic [2:0] cs_q, cs_d;
    logic [1:0] mosi_q, mosi_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       load_q, load_d;
    logic [7:0] tx_q, tx_d;

    logic sclk_rise, sclk_fall, cs_low, cs_fall;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_low    = ~cs_q[1];
    assign cs_fall   = ~cs_q[1] & cs_q[2];

    // Synchronise, capture bits on sclk rise, and shift status out on sclk fall.
    always_comb begin
        sclk_d       = {sclk_q[1:0], sclk};
        cs_d         = {cs_q[1:0], cs_n};
        mosi_d       = {mosi_q[0], mosi};
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_valid_d = 1'b0;
        rx_byte_d    = rx_byte_q;
        // Status is reloaded one cycle after byte_valid so it reflects the decoded byte.
        load_d       = byte_valid_q;
        tx_d         = tx_q;

        if (!cs_low) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (sclk_rise) begin
            shift_d   = {shift_q[6:0], mosi_q[1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                rx_byte_d    = {shift_q[6:0], mosi_q[1]};
            end
        end

        // The fall that follows a byte's last rise presents the next byte's MSB, so no shift there.
        if (cs_fall || load_q) begin
            tx_d = status;
        end else if (cs_low && sclk_fall && (bit_cnt_q != 3'd0)) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    // State registers; chip select resets to its idle (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q       <= '0;
            cs_q         <= 3'b111;
            mosi_q       <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            byte_valid_q <= 1'b0;
            rx_byte_q    <= '0;
            load_q       <= 1'b0;
            tx_q         <= '0;
        end else begin
            sclk_q       <= sclk_d;
            cs_q         <= cs_d;
            mosi_q       <= mosi_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_valid_q <= byte_valid_d;
            rx_byte_q    <= rx_byte_d;
            load_q       <= load_d;
            tx_q         <= tx_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign rx_byte    = rx_byte_q;
    assign miso       = tx_q[7];

endmodule

// File: rtl/spi_fb_writer.sv
// rtl/spi_fb_writer.sv - SPI command decoder writing pixels into the VGA back buffer
module spi_fb_writer
    import vga_spi_pkg::*;
#(
    parameter  int RES_X           = 320,
    parameter  int RES_Y           = 240,
    parameter  int BYTES_PER_PIXEL = 1,
    localparam int ADDR_WIDTH      = $clog2(RES_X * RES_Y),
    localparam int PIX_W           = pix_width(BYTES_PER_PIXEL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [PIX_W-1:0]      wr_data,
    output logic [ADDR_WIDTH-1:0] addr_count,
    output logic                  swap_req,
    input  logic                  swap_ack,
    output logic                  frame_done,
    output logic                  cmd_err
);

    localparam int NUM_PIX    = RES_X * RES_Y;
    localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
    localparam int SHADOW_W   = ADDR_BYTES * 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIX - 1);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic [7:0] status;

    fsm_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_count_q, addr_count_d;
    logic [3:0]            red_q, red_d;
    logic [SHADOW_W-1:0]   shadow_q, shadow_d;
    logic [2:0]            addr_left_q, addr_left_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]      wr_data_q, wr_data_d;
    logic                  frame_done_q, frame_done_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  swap_req_q, swap_req_d;

    logic                  do_write;
    logic [PIX_W-1:0]      pix;
    logic [SHADOW_W-1:0]   shadow_next;

    assign status = {swap_req_q, cmd_err_q, state_q != IDLE, 5'b0};

    spi_byte_rx u_rx (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .mosi       (mosi),
        .status     (status),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .miso       (miso)
    );

    // Decode each received byte into writes, address loads and swap requests.
    always_comb begin
        state_d      = state_q;
        addr_count_d = addr_count_q;
        red_d        = red_q;
        shadow_d     = shadow_q;
        addr_left_d  = addr_left_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        cmd_err_d    = cmd_err_q;
        swap_req_d   = swap_req_q;
        do_write     = 1'b0;
        pix          = '0;
        shadow_next  = SHADOW_W'({shadow_q, rx_byte});

        // Acknowledge clears first so that a SWAP in the same cycle keeps the request raised.
        if (swap_req_q && swap_ack) begin
            swap_req_d = 1'b0;
        end

        if (byte_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_byte[7]) begin
                        case (rx_byte)
                            CMD_ALIGN: begin
                                addr_count_d = '0;
                                cmd_err_d    = 1'b0;
                            end
                            CMD_SWAP: swap_req_d = 1'b1;
                            CMD_SET_ADDR: begin
                                state_d     = ADDR;
                                addr_left_d = 3'(ADDR_BYTES);
                                shadow_d    = '0;
                            end
                            default: cmd_err_d = 1'b1;
                        endcase
                    end else if (BYTES_PER_PIXEL == 1) begin
                        do_write = 1'b1;
                        pix      = PIX_W'(rx_byte[5:0]);
                    end else begin
                        red_d   = rx_byte[3:0];
                        state_d = PIX_LO;
                    end
                end
                PIX_LO: begin
                    do_write = 1'b1;
                    pix      = PIX_W'({red_q, rx_byte});
                    state_d  = IDLE;
                end
                ADDR: begin
                    shadow_d    = shadow_next;
                    addr_left_d = addr_left_q - 3'd1;
                    if (addr_left_q == 3'd1) begin
                        state_d = IDLE;
                        if (32'(shadow_next) < 32'(NUM_PIX)) begin
                            addr_count_d = shadow_next[ADDR_WIDTH-1:0];
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_count_q;
            wr_data_d = pix;
            if (addr_count_q == LAST_ADDR) begin
                addr_count_d = '0;
                frame_done_d = 1'b1;
            end else begin
                addr_count_d = addr_count_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Decoder state and registered outputs; reset drops any partial multi-byte sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_count_q <= '0;
            red_q        <= '0;
            shadow_q     <= '0;
            addr_left_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            cmd_err_q    <= 1'b0;
            swap_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_count_q <= addr_count_d;
            red_q        <= red_d;
            shadow_q     <= shadow_d;
            addr_left_q  <= addr_left_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            cmd_err_q    <= cmd_err_d;
            swap_req_q   <= swap_req_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign addr_count = addr_count_q;
    assign swap_req   = swap_req_q;
    assign frame_done = frame_done_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_spi_fb_writer.sv
// tb/tb_spi_fb_writer.sv - self-checking bench for spi_fb_writer at one and two bytes per pixel
module tb_spi_fb_writer;

    localparam int TOTAL      = 320 * 240;
    localparam int ADDR_BYTES = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic swap_ack = 1'b0;

    logic        a_miso, a_wr_en, a_swap_req, a_frame_done, a_cmd_err;
    logic [16:0] a_wr_addr, a_addr_count;
    logic [5:0]  a_wr_data;
    logic        b_miso, b_wr_en, b_swap_req, b_frame_done, b_cmd_err;
    logic [16:0] b_wr_addr, b_addr_count;
    logic [11:0] b_wr_data;

    int checks = 0;
    int errors = 0;
    int stray  = 0;

    logic [31:0] act0[$], act1[$], exp0[$], exp1[$];
    int m_addr[2], m_err[2], m_swap[2], m_left[2], m_sh[2], m_hi[2];

    always #5 clk = ~clk;

    spi_fb_writer #(.BYTES_PER_PIXEL(1)) dut_a (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(a_miso),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .addr_count(a_addr_count),
        .swap_req(a_swap_req), .swap_ack(swap_ack), .frame_done(a_frame_done), .cmd_err(a_cmd_err)
    );

    spi_fb_writer #(.BYTES_PER_PIXEL(2)) dut_b (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(b_miso),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .addr_count(b_addr_count),
        .swap_req(b_swap_req), .swap_ack(swap_ack), .frame_done(b_frame_done), .cmd_err(b_cmd_err)
    );

    // Record every write strobe as {0, frame_done, addr, data}.
    always @(negedge clk) begin
        if (a_wr_en) act0.push_back({1'b0, a_frame_done, a_wr_addr, 7'b0, a_wr_data});
        if (b_wr_en) act1.push_back({1'b0, b_frame_done, b_wr_addr, 1'b0, b_wr_data});
        if (a_frame_done && !a_wr_en) stray++;
        if (b_frame_done && !b_wr_en) stray++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 0; m_err[k] = 0; m_swap[k] = 0; m_left[k] = 0; m_sh[k] = 0; m_hi[k] = -1;
        end
        exp0.delete(); exp1.delete(); act0.delete(); act1.delete();
    endtask

    task automatic model_write(input int k, input int pix);
        logic [31:0] e;
        logic fd;
        fd = (m_addr[k] == TOTAL - 1);
        e = {1'b0, fd, 17'(m_addr[k]), 13'(pix)};
        if (k == 0) exp0.push_back(e); else exp1.push_back(e);
        m_addr[k] = (m_addr[k] + 1) % TOTAL;
    endtask

    task automatic model_byte(input int k, input logic [7:0] b);
        int bpp;
        bpp = (k == 0) ? 1 : 2;
        if (m_left[k] > 0) begin
            m_sh[k] = m_sh[k] * 256 + int'(b);
            m_left[k]--;
            if (m_left[k] == 0) begin
                if (m_sh[k] < TOTAL) m_addr[k] = m_sh[k]; else m_err[k] = 1;
            end
        end else if (m_hi[k] >= 0) begin
            model_write(k, m_hi[k] * 256 + int'(b));
            m_hi[k] = -1;
        end else if (b >= 8'h80) begin
            if (b == 8'h80) begin m_addr[k] = 0; m_err[k] = 0; end
            else if (b == 8'h81) m_swap[k] = 1;
            else if (b == 8'h82) begin m_left[k] = ADDR_BYTES; m_sh[k] = 0; end
            else m_err[k] = 1;
        end else if (bpp == 1) begin
            model_write(k, int'(b) % 64);
        end else begin
            m_hi[k] = int'(b) % 16;
        end
    endtask

    function automatic logic [7:0] status_of(input int k);
        logic busy;
        busy = (m_left[k] > 0) || (m_hi[k] >= 0);
        return {m_swap[k] != 0, m_err[k] != 0, busy, 5'b0};
    endfunction

    task automatic check_state(input string tag);
        chk({tag, " wr_count_a"}, act0.size(), exp0.size());
        for (int i = 0; i < exp0.size() && i < act0.size(); i++) chk({tag, " write_a"}, act0[i], exp0[i]);
        chk({tag, " wr_count_b"}, act1.size(), exp1.size());
        for (int i = 0; i < exp1.size() && i < act1.size(); i++) chk({tag, " write_b"}, act1[i], exp1[i]);
        act0.delete(); act1.delete(); exp0.delete(); exp1.delete();
        chk({tag, " addr_count_a"}, a_addr_count, m_addr[0]);
        chk({tag, " addr_count_b"}, b_addr_count, m_addr[1]);
        chk({tag, " cmd_err_a"}, a_cmd_err, m_err[0]);
        chk({tag, " cmd_err_b"}, b_cmd_err, m_err[1]);
        chk({tag, " swap_req_a"}, a_swap_req, m_swap[0]);
        chk({tag, " swap_req_b"}, b_swap_req, m_swap[1]);
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] got);
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            repeat (4) @(negedge clk);
            got[i] = a_miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        logic [7:0] exp_st, got;
        exp_st = status_of(0);
        spi_byte(b, got);
        repeat (12) @(negedge clk);
        model_byte(0, b);
        model_byte(1, b);
        chk({tag, " miso"}, got, exp_st);
        check_state(tag);
    endtask

    task automatic cs_set(input logic v);
        cs_n = v;
        repeat (8) @(negedge clk);
    endtask

    task automatic ack_pulse();
        swap_ack = 1'b1;
        @(negedge clk);
        swap_ack = 1'b0;
        m_swap[0] = 0;
        m_swap[1] = 0;
    endtask

    initial begin
        logic        acc_a, acc_b, seen;
        logic [7:0]  got;
        int          r, addr;

        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;

        acc_a = 1'b0; acc_b = 1'b0;
        repeat (100) begin
            @(negedge clk);
            acc_a |= |{a_miso, a_wr_en, a_wr_addr, a_wr_data, a_addr_count, a_swap_req, a_frame_done, a_cmd_err};
            acc_b |= |{b_miso, b_wr_en, b_wr_addr, b_wr_data, b_addr_count, b_swap_req, b_frame_done, b_cmd_err};
        end
        chk("idle_outputs_a", acc_a, 1'b0);
        chk("idle_outputs_b", acc_b, 1'b0);

        cs_set(1'b0);
        send(8'h80, "align");
        send(8'h1B, "pix0");
        send(8'h1B, "pix1");
        send(8'h3F, "pix2");
        chk("three_pixels_addr_count", a_addr_count, 17'd3);

        send(8'h81, "swap");
        repeat (50) @(negedge clk);
        chk("swap_held", a_swap_req, 1'b1);
        cs_set(1'b1);
        ack_pulse();
        chk("swap_cleared", a_swap_req, 1'b0);
        repeat (3) @(negedge clk);
        ack_pulse();
        check_state("ack_idle");
        cs_set(1'b0);

        send(8'h82, "set_addr_cmd");
        send(8'h01, "set_addr_hi");
        send(8'h2B, "set_addr_mid");
        send(8'hFF, "set_addr_lo");
        chk("set_addr_loaded", a_addr_count, 17'd76799);
        send(8'h2A, "wrap_write");
        chk("wrap_addr_count", a_addr_count, 17'd0);

        send(8'h82, "bad_addr_cmd");
        send(8'h01, "bad_addr_hi");
        send(8'h2C, "bad_addr_mid");
        send(8'h00, "bad_addr_lo");
        chk("bad_addr_err", a_cmd_err, 1'b1);
        send(8'h85, "bad_cmd");
        send(8'h80, "align_clears_err");
        chk("align_err_clear", a_cmd_err, 1'b0);

        for (int i = 7; i >= 4; i--) begin
            mosi = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        cs_set(1'b1);
        cs_set(1'b0);
        send(8'h2A, "after_partial");

        send(8'h80, "bpp2_align");
        send(8'h05, "bpp2_hi");
        send(8'hA3, "bpp2_lo");

        cs_set(1'b1);
        swap_ack = 1'b1;
        cs_set(1'b0);
        seen = 1'b0;
        fork
            spi_byte(8'h81, got);
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (a_swap_req) seen = 1'b1;
            end
        join
        repeat (12) @(negedge clk);
        swap_ack = 1'b0;
        chk("swap_under_ack_miso", got, status_of(0));
        chk("swap_wins_over_ack", seen, 1'b1);
        chk("swap_under_ack_done", a_swap_req, 1'b0);
        cs_set(1'b1);
        cs_set(1'b0);

        send(8'h82, "pre_reset_cmd");
        send(8'h01, "pre_reset_hi");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        send(8'h2A, "after_reset");

        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                send(8'($urandom_range(0, 127)), "rnd_pix");
            end else if (r < 70) begin
                if (r < 63) addr = int'($urandom_range(0, TOTAL - 1));
                else if (r < 69) addr = TOTAL - 1 - int'($urandom_range(0, 2));
                else addr = TOTAL + int'($urandom_range(0, 1000));
                send(8'h82, "rnd_set_cmd");
                send(8'(addr >> 16), "rnd_set_hi");
                send(8'(addr >> 8), "rnd_set_mid");
                send(8'(addr), "rnd_set_lo");
            end else if (r < 78) begin
                send(8'h80, "rnd_align");
            end else if (r < 84) begin
                send(8'h81, "rnd_swap");
            end else if (r < 90) begin
                send(8'($urandom_range(131, 255)), "rnd_bad_cmd");
            end else begin
                cs_set(1'b1);
                ack_pulse();
                cs_set(1'b0);
                check_state("rnd_ack");
            end
        end

        cs_set(1'b1);
        chk("stray_frame_done", stray, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_fb_writer.md
Name: spi_fb_writer

Overview:
Parametrised SPI-slave framebuffer writer: the next generation of the VGA SPI link.
- Receives SPI mode-0 bytes (MSB first) and decodes commands and pixel data.
- Writes pixels through a one-cycle write strobe into the back buffer of the VGA framebuffer.
- Adds configurable pixel depth, random-access address load, a swap request/acknowledge handshake, end-of-frame wrap, error flagging, and status readback on miso.

Parameters:
RES_X, 320, horizontal resolution in pixels
RES_Y, 240, vertical resolution in pixels
BYTES_PER_PIXEL, 1, bytes per pixel: 1 gives 6-bit RGB222, 2 gives 12-bit RGB444
ADDR_WIDTH, $clog2(RES_X*RES_Y), derived localparam, pixel address width
PIX_W, 6 if BYTES_PER_PIXEL=1 else 12, derived localparam, write-data width

Ports:
clk  in  1  system clock (50 MHz nominal)
rst  in  1  asynchronous, active-high reset
sclk  in  1  SPI clock, asynchronous to clk, must be at most clk/8
cs_n  in  1  SPI chip select, active low, asynchronous
mosi  in  1  SPI data in
miso  out  1  SPI data out, status byte
wr_en  out  1  one-cycle framebuffer write strobe
wr_addr  out  ADDR_WIDTH  write address
wr_data  out  PIX_W  write pixel
addr_count  out  ADDR_WIDTH  next pixel address
swap_req  out  1  buffer swap request, level
swap_ack  in  1  swap acknowledge from the display side
frame_done  out  1  one-cycle pulse when the address wraps
cmd_err  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0; FSM in IDLE; bit counter 0; miso 0.
- Synchronisers: sclk, cs_n and mosi each pass through a 2-flop synchroniser.
- Edge detect: rising and falling sclk edges are detected on the synchronised signal.
- Byte capture: mosi is shifted in on each rising edge while cs_n is low.
  - byte_valid pulses for one cycle on the 8th bit.
- cs_n high: clears the bit counter and discards any partial byte. FSM state persists across cs_n toggles.
- Latency: decoded outputs (wr_en, swap_req set, cmd_err, frame_done) are registered 1 clk after byte_valid.
- IDLE, byte with bit7=1 (command):
  - 0x80 ALIGN: addr_count=0, cmd_err cleared.
  - 0x81 SWAP: swap_req set.
  - 0x82 SET_ADDR: go to ADDR and load ADDR_BYTES=ceil(ADDR_WIDTH/8) big-endian bytes.
  - 0x83 to 0xFF: cmd_err set, no other effect.
- IDLE, byte with bit7=0, BYTES_PER_PIXEL=1:
  - wr_en=1, wr_addr=addr_count, wr_data=byte[5:0]; addr_count then increments.
  - No warm-up byte: the first pixel after ALIGN is written to address 0.
- IDLE, byte with bit7=0, BYTES_PER_PIXEL=2:
  - byte[3:0] is latched as R; go to PIX_LO.
- PIX_LO: any byte (bit7 not a command) supplies {G,B}.
  - Write wr_data={R,byte}, increment addr_count, return to IDLE.
- ADDR: bytes accumulate in a shadow register.
  - After the last byte: if value < RES_X*RES_Y, load addr_count; else set cmd_err and leave addr_count unchanged.
  - Return to IDLE.
- Wrap: a write at RES_X*RES_Y-1 sets addr_count=0 and pulses frame_done in the same cycle as wr_en.
- Swap handshake:
  - swap_req stays high until swap_ack is sampled high, then clears the next cycle.
  - A SWAP decoded in the same cycle as swap_ack keeps swap_req=1.
  - A repeat SWAP while pending has no extra effect.
  - swap_ack with no request pending is ignored.
- miso:
  - Status byte = {swap_req, cmd_err, state!=IDLE, 5'b0}.
  - Loaded on synchronised cs_n fall and after each byte_valid.
  - Shifted MSB first on each synchronised sclk falling edge.
  - The first bit is driven within 3 clk of the load event.
- Reset mid-operation: discards the partial byte and any pending multi-byte sequence.

Decomposition:
- Package vga_spi_pkg holds:
  - command constants CMD_ALIGN=8'h80, CMD_SWAP=8'h81, CMD_SET_ADDR=8'h82;
  - FSM enum {IDLE, PIX_LO, ADDR};
  - a function returning PIX_W from BYTES_PER_PIXEL.
- Sub-module spi_byte_rx owns the synchronisers, edge detection, rx shift register, byte_valid, bit counter and miso tx shift register.
- The top level holds the decode FSM, address counter and swap handshake.

Test Plan:
1. Reset then release, no SPI activity -> every output 0 and addr_count=0 for 100 clk.
2. BPP=1: send 0x80, 0x1B, 0x1B, 0x3F -> three wr_en pulses at addr 0/1/2 with data 6'h1B/6'h1B/6'h3F; addr_count=3.
3. Send 0x81 -> swap_req=1 and held for 50 clk; pulse swap_ack -> swap_req=0 next cycle.
   - Then swap_ack with nothing pending -> no change.
4. Send 0x82, 0x01, 0x2B, 0xFF (addr 76799), then 0x2A -> wr_addr=76799, wr_data=6'h2A, frame_done=1 in the same cycle; addr_count=0.
5. SET_ADDR with 0x01, 0x2C, 0x00 (76800) -> cmd_err=1, addr_count unchanged; 0x85 -> cmd_err stays 1; 0x80 -> cmd_err=0.
6. cs_n raised after 4 bits, then full byte 0x2A -> only 0x2A decoded.
   - BPP=2: 0x05, 0xA3 -> wr_data=12'h5A3.
   - miso during the next byte reads {swap_req, cmd_err, 0, 00000}.
